// File: rtl/gate_mode_explorer_pkg.sv
// gate_mode_explorer_pkg: mode codes and LED bit positions shared by the gate demonstrator.
package gate_mode_explorer_pkg;
  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5
  } mode_e;
  localparam mode_e MODE_LAST = MODE_XNOR;
  localparam int LED_RES     = 0;
  localparam int LED_MODE_LO = 1;
  localparam int LED_OP0     = 4;
  localparam int LED_OP1     = 5;
endpackage

// File: rtl/gate_mode_explorer_btn_debounce.sv
// btn_debounce: two-flop synchroniser plus stable-count debouncer for one active-low button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic btn_raw_n,
  output logic btn_pressed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic          r_s1, r_s2, r_stable;
  logic [CW-1:0] r_cnt;
  // Any sample matching the accepted level discards all accumulated count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_s1 <= btn_raw_n;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) r_cnt <= '0;
      else if (r_cnt == CNT_MAX) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else r_cnt <= r_cnt + CW'(1);
    end
  end
  assign btn_pressed = ~r_stable;
endmodule

// File: rtl/gate_mode_explorer.sv
// gate_mode_explorer: debounced operand/mode buttons driving a selectable reduction gate onto active-low LEDs.
module gate_mode_explorer
  import gate_mode_explorer_pkg::*;
#(
  parameter int N_IN            = 2,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [N_IN-1:0] sys_btn,
  input  logic            sys_btn_mode,
  output logic [5:0]      led
);
  logic [N_IN:0]   w_raw, w_pressed;
  logic [N_IN-1:0] w_p;
  logic            w_mode_p, w_res;
  logic            r_press_q;
  mode_e           r_mode, w_mode_nxt;
  logic [5:0]      w_led;
  assign w_raw    = {sys_btn_mode, sys_btn};
  assign w_p      = w_pressed[N_IN-1:0];
  assign w_mode_p = w_pressed[N_IN];
  // Index N_IN is the mode button; the rest are operands.
  genvar i;
  generate
    for (i = 0; i <= N_IN; i++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .btn_raw_n  (w_raw[i]),
        .btn_pressed(w_pressed[i])
      );
    end
  endgenerate
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode    <= MODE_AND;
      r_press_q <= 1'b0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_press_q <= w_mode_p;
    end
  end
  always_comb begin
    w_mode_nxt = r_mode;
    if (w_mode_p && !r_press_q)
      w_mode_nxt = (r_mode == MODE_LAST) ? MODE_AND : mode_e'(r_mode + 3'd1);
  end
  always_comb begin
    w_res = 1'b0;
    case (r_mode)
      MODE_AND:  w_res = &w_p;
      MODE_OR:   w_res = |w_p;
      MODE_XOR:  w_res = ^w_p;
      MODE_NAND: w_res = ~&w_p;
      MODE_NOR:  w_res = ~|w_p;
      MODE_XNOR: w_res = ~^w_p;
      default:   w_res = 1'b0;
    endcase
  end
  always_comb begin
    w_led                      = '1;
    w_led[LED_RES]             = ~w_res;
    w_led[LED_MODE_LO +: 3]    = ~r_mode;
    w_led[LED_OP0]             = ~w_p[0];
    w_led[LED_OP1]             = ~w_p[1];
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) led <= 6'h3F;
    else led <= w_led;
  end
endmodule

// File: tb/tb_gate_mode_explorer.sv
// tb_gate_mode_explorer: scoreboard bench for the gate demonstrator at short debounce (N_IN=2 and N_IN=3 instances).
module tb_gate_mode_explorer;
  typedef struct {
    int          sel;
    int          at;
    logic [5:0]  exp;
    string       tag;
  } sb_t;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_a;
  logic       mode_a;
  logic [5:0] led_a;
  logic [2:0] btn_b;
  logic       mode_b;
  logic [5:0] led_b;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  sb_t        sb[$];
  sb_t        mon_e;
  gate_mode_explorer #(.N_IN(2), .DEBOUNCE_CYCLES(4)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .sys_btn(btn_a), .sys_btn_mode(mode_a), .led(led_a)
  );
  gate_mode_explorer #(.N_IN(3), .DEBOUNCE_CYCLES(4)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .sys_btn(btn_b), .sys_btn_mode(mode_b), .led(led_b)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask
  // Expected LED word for a given mode index and pressed vector of width n.
  function automatic logic [5:0] led_m(input int m, input logic [2:0] p, input int n);
    logic a, o, x, r;
    logic [2:0] pm;
    logic [2:0] mb;
    pm = (n == 3) ? p : {1'b0, p[1:0]};
    a  = (n == 3) ? &p : &p[1:0];
    o  = |pm;
    x  = ^pm;
    r  = (m == 0) ? a : (m == 1) ? o : (m == 2) ? x : (m == 3) ? ~a : (m == 4) ? ~o : ~x;
    mb = 3'(m);
    return {~p[1], ~p[0], ~mb, ~r};
  endfunction
  task automatic push_exp(input int sel, input int dly, input logic [5:0] v, input string tag);
    sb_t e;
    int  idx;
    e.sel = sel;
    e.at  = cyc + dly;
    e.exp = v;
    e.tag = tag;
    idx   = sb.size();
    while (idx > 0 && sb[idx-1].at > e.at) idx--;
    sb.insert(idx, e);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, {26'b0, (mon_e.sel != 0) ? led_b : led_a}, {26'b0, mon_e.exp});
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n  = 1'b0;
    btn_a  = '1;
    mode_a = 1'b1;
    btn_b  = '1;
    mode_b = 1'b1;
    tick(3);
    chk("rst_hold_a", {26'b0, led_a}, 32'h3F);
    chk("rst_hold_b", {26'b0, led_b}, 32'h3F);
    rst_n = 1'b1;
    push_exp(0, 10, 6'h3F, "post_rst");
    tick(12);
    btn_a[0] = 1'b0;
    push_exp(0, 6, led_m(0, 3'b000, 2), "op0_before");
    push_exp(0, 7, led_m(0, 3'b001, 2), "op0_edge");
    tick(10);
    btn_a[1] = 1'b0;
    push_exp(0, 7, 6'b001110, "and_11");
    tick(10);
    btn_a = '1;
    push_exp(0, 8, 6'h3F, "release_all");
    tick(10);
    for (int i = 2; i <= 14; i += 2) push_exp(0, i, 6'h3F, "bounce_reject");
    btn_a[0] = 1'b0; tick(3);
    btn_a[0] = 1'b1; tick(1);
    btn_a[0] = 1'b0; tick(3);
    btn_a[0] = 1'b1; tick(8);
    btn_a[0] = 1'b0;
    push_exp(0, 7, led_m(0, 3'b001, 2), "bounce_accept");
    tick(10);
    for (int i = 1; i <= 7; i++) begin
      mode_a = 1'b0;
      push_exp(0, 7, led_m((i - 1) % 6, 3'b001, 2), "mode_before");
      push_exp(0, 8, led_m(i % 6, 3'b001, 2), "mode_step");
      tick(10);
      mode_a = 1'b1;
      push_exp(0, 9, led_m(i % 6, 3'b001, 2), "mode_release");
      tick(10);
    end
    for (int i = 1; i <= 2; i++) begin
      mode_b = 1'b0;
      push_exp(1, 8, led_m(i, 3'b000, 3), "b_mode_step");
      tick(10);
      mode_b = 1'b1;
      tick(10);
    end
    btn_b = 3'b000;
    push_exp(1, 7, led_m(2, 3'b111, 3), "xor3_all");
    tick(10);
    btn_b[2] = 1'b1;
    push_exp(1, 7, led_m(2, 3'b011, 3), "xor3_rel2");
    tick(10);
    mode_a = 1'b0;
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_a", {26'b0, led_a}, 32'h3F);
    chk("rst_mid_b", {26'b0, led_b}, 32'h3F);
    tick(2);
    rst_n = 1'b1;
    push_exp(0, 6, 6'h3F, "rst_rel_quiet");
    push_exp(0, 7, led_m(0, 3'b001, 2), "rst_rel_op0");
    push_exp(0, 8, led_m(1, 3'b001, 2), "rst_rel_mode");
    tick(10);
    for (int i = 0; i < 100 && sb.size() > 0; i++) tick(1);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
